// File: rtl/mlp_weight_mem_ctrl.sv
// rtl/mlp_weight_mem_ctrl.sv - arbiter sharing a single-port weight memory between host and burst reader
module mlp_weight_mem_ctrl #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_gnt,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  host_rvalid,
  input  logic                  burst_req,
  input  logic [ADDR_WIDTH-1:0] burst_addr,
  input  logic [ADDR_WIDTH:0]   burst_len,
  output logic                  burst_ack,
  output logic                  burst_busy,
  output logic                  burst_valid,
  output logic [DATA_WIDTH-1:0] burst_data,
  output logic                  burst_last,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wr_en,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                state, state_nxt;
  logic                  host_prio;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH:0]   cnt;
  logic                  len_nz;
  logic                  final_beat;

  assign len_nz     = (burst_len != '0);
  assign final_beat = (state == BURST) && (cnt == (ADDR_WIDTH+1)'(1));

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (burst_ack && len_nz) state_nxt = BURST;
      BURST:   if (final_beat)          state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Host wins when it holds priority or when no real burst (len!=0) is pending;
  // a zero-length burst is only acknowledged if the host is not granted.
  always_comb begin
    host_gnt    = 1'b0;
    burst_ack   = 1'b0;
    burst_busy  = 1'b0;
    mem_addr    = '0;
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    case (state)
      IDLE: begin
        if (host_req && (host_prio || !(burst_req && len_nz))) host_gnt  = 1'b1;
        else if (burst_req)                                   burst_ack = 1'b1;
        if (host_gnt) begin
          mem_addr    = host_addr;
          mem_wr_en   = host_we;
          mem_wr_data = host_wdata;
        end
      end
      BURST: begin
        burst_busy = 1'b1;
        mem_addr   = ptr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      host_prio   <= 1'b0;
      ptr         <= '0;
      cnt         <= '0;
      host_rdata  <= '0;
      host_rvalid <= 1'b0;
      burst_valid <= 1'b0;
      burst_data  <= '0;
      burst_last  <= 1'b0;
    end else begin
      host_rvalid <= host_gnt && !host_we;
      if (host_gnt && !host_we) host_rdata <= mem_rd_data;

      burst_valid <= burst_busy;
      burst_data  <= burst_busy ? mem_rd_data : '0;
      burst_last  <= final_beat;

      if (burst_ack && len_nz) begin
        ptr <= burst_addr;
        cnt <= burst_len;
      end else if (burst_busy) begin
        ptr <= ptr + 1'b1;
        cnt <= cnt - 1'b1;
      end

      if (host_gnt)        host_prio <= 1'b0;
      else if (final_beat) host_prio <= 1'b1;
    end
  end

endmodule
